// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x oversampled async receiver feeding a small byte FIFO.
// Each FIFO entry holds {parity_err, data}; the host side pops from the head.
module uart_rx_fifo #(
   parameter int SYS_CLK_FREQ   = 100_000_000,
   parameter int BAUD_RATE      = 38400,
   parameter int PARITY_MODE    = 0,
   parameter int FIFO_ADDR_BITS = 2
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       rx_in,
   input  logic       rd_en_in,
   output logic [7:0] rx_data_out,
   output logic       parity_err_out,
   output logic       rx_empty_out,
   output logic       rx_full_out,
   output logic       frame_err_out,
   output logic       overrun_out,
   output logic       busy_out
);

   localparam int DIV = SYS_CLK_FREQ / (BAUD_RATE * 16);
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [DW-1:0] DIV_ONE = DW'(1);
   localparam int AW = FIFO_ADDR_BITS;
   localparam int DEPTH = 1 << AW;
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP, WAIT_IDLE
   } state_t;

   logic sync1, rx_s, rx_prev;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         sync1   <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         sync1   <= rx_in;
         rx_s    <= sync1;
         rx_prev <= rx_s;
      end
   end

   logic [DW-1:0] div_cnt;
   logic          tick;

   assign tick = (div_cnt == DIV_LAST);

   always_ff @(posedge clk_in) begin
      if (rst_in)    div_cnt <= '0;
      else if (tick) div_cnt <= '0;
      else           div_cnt <= div_cnt + DIV_ONE;
   end

   state_t     state, state_n;
   logic [3:0] tick_cnt, tick_cnt_n;
   logic [2:0] bit_idx, bit_idx_n;
   logic [7:0] shreg, shreg_n;
   logic       s7, s7_n, s8, s8_n;
   logic       perr, perr_n;
   logic       maj, at_mid, at_end;
   logic       push, frame_err_n;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state    <= IDLE;
         tick_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         s7       <= 1'b1;
         s8       <= 1'b1;
         perr     <= 1'b0;
      end else begin
         state    <= state_n;
         tick_cnt <= tick_cnt_n;
         bit_idx  <= bit_idx_n;
         shreg    <= shreg_n;
         s7       <= s7_n;
         s8       <= s8_n;
         perr     <= perr_n;
      end
   end

   // Bit value is the 2-of-3 vote over ticks 7, 8 and 9 of each bit cell.
   always_comb begin
      state_n     = state;
      tick_cnt_n  = tick_cnt;
      bit_idx_n   = bit_idx;
      shreg_n     = shreg;
      s7_n        = s7;
      s8_n        = s8;
      perr_n      = perr;
      push        = 1'b0;
      frame_err_n = 1'b0;
      maj    = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
      at_mid = tick && (tick_cnt == 4'd9);
      at_end = tick && (tick_cnt == 4'd15);
      if (tick) begin
         if (tick_cnt == 4'd7) s7_n = rx_s;
         if (tick_cnt == 4'd8) s8_n = rx_s;
         tick_cnt_n = tick_cnt + 4'd1;
      end
      unique case (state)
         IDLE: begin
            if (rx_prev && !rx_s) begin
               state_n    = START;
               tick_cnt_n = '0;
               perr_n     = 1'b0;
            end
         end
         START: begin
            if (at_mid && maj) begin
               state_n = IDLE;
            end else if (at_end) begin
               state_n    = DATA;
               tick_cnt_n = '0;
               bit_idx_n  = '0;
            end
         end
         DATA: begin
            if (at_mid) shreg_n = {maj, shreg[7:1]};
            if (at_end) begin
               tick_cnt_n = '0;
               if (bit_idx == 3'd7)
                  state_n = (PARITY_MODE != 0) ? PARITY : STOP;
               else
                  bit_idx_n = bit_idx + 3'd1;
            end
         end
         PARITY: begin
            if (at_mid) begin
               if (PARITY_MODE == 2) perr_n = ~(^shreg ^ maj);
               else                  perr_n = ^shreg ^ maj;
            end
            if (at_end) begin
               state_n    = STOP;
               tick_cnt_n = '0;
            end
         end
         STOP: begin
            // Act mid stop bit so a back-to-back start edge is not missed.
            if (at_mid) begin
               if (maj) begin
                  push    = 1'b1;
                  state_n = IDLE;
               end else begin
                  frame_err_n = 1'b1;
                  state_n     = WAIT_IDLE;
               end
            end
         end
         WAIT_IDLE: begin
            if (rx_s) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   logic [8:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count, count_n;
   logic          pop, push_ok, overrun_n;

   always_comb begin
      pop       = rd_en_in && !rx_empty_out;
      push_ok   = push && (!rx_full_out || pop);
      overrun_n = push && rx_full_out && !pop;
      count_n   = count;
      if (push_ok && !pop)      count_n = count + CNT_ONE;
      else if (!push_ok && pop) count_n = count - CNT_ONE;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         rx_empty_out  <= 1'b1;
         rx_full_out   <= 1'b0;
         frame_err_out <= 1'b0;
         overrun_out   <= 1'b0;
         busy_out      <= 1'b0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= {perr, shreg};
            wr_ptr      <= wr_ptr + PTR_ONE;
         end
         if (pop) rd_ptr <= rd_ptr + PTR_ONE;
         count         <= count_n;
         rx_empty_out  <= (count_n == '0);
         rx_full_out   <= (count_n == CNT_FULL);
         frame_err_out <= frame_err_n;
         overrun_out   <= overrun_n;
         busy_out      <= (state_n != IDLE);
      end
   end

   assign {parity_err_out, rx_data_out} = mem[rd_ptr];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: one instance per parity mode,
// 160 clocks per bit (DIV = 10).
module tb_uart_rx_fifo;

   localparam int F   = 1_600_000;
   localparam int B   = 10000;
   localparam int BIT = 160;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx   [3];
   logic       rd   [3];
   logic [7:0] dat  [3];
   logic       perr [3];
   logic       emp  [3];
   logic       ful  [3];
   logic       ferr [3];
   logic       ovr  [3];
   logic       bsy  [3];

   int  ferr_cnt [3] = '{0, 0, 0};
   int  ovr_cnt  [3] = '{0, 0, 0};
   int  total = 0;
   int  bad = 0;
   int  o, fe;
   bit  found;

   always #5 clk = ~clk;

   uart_rx_fifo #(.SYS_CLK_FREQ(F), .BAUD_RATE(B), .PARITY_MODE(0)) u0 (
      .clk_in(clk), .rst_in(rst), .rx_in(rx[0]), .rd_en_in(rd[0]),
      .rx_data_out(dat[0]), .parity_err_out(perr[0]),
      .rx_empty_out(emp[0]), .rx_full_out(ful[0]),
      .frame_err_out(ferr[0]), .overrun_out(ovr[0]), .busy_out(bsy[0])
   );

   uart_rx_fifo #(.SYS_CLK_FREQ(F), .BAUD_RATE(B), .PARITY_MODE(1)) u1 (
      .clk_in(clk), .rst_in(rst), .rx_in(rx[1]), .rd_en_in(rd[1]),
      .rx_data_out(dat[1]), .parity_err_out(perr[1]),
      .rx_empty_out(emp[1]), .rx_full_out(ful[1]),
      .frame_err_out(ferr[1]), .overrun_out(ovr[1]), .busy_out(bsy[1])
   );

   uart_rx_fifo #(.SYS_CLK_FREQ(F), .BAUD_RATE(B), .PARITY_MODE(2)) u2 (
      .clk_in(clk), .rst_in(rst), .rx_in(rx[2]), .rd_en_in(rd[2]),
      .rx_data_out(dat[2]), .parity_err_out(perr[2]),
      .rx_empty_out(emp[2]), .rx_full_out(ful[2]),
      .frame_err_out(ferr[2]), .overrun_out(ovr[2]), .busy_out(bsy[2])
   );

   // Pulse counters: a count of 1 means high for exactly one cycle.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (ferr[i] === 1'b1) ferr_cnt[i]++;
         if (ovr[i] === 1'b1) ovr_cnt[i]++;
      end
   end

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic bitt(input int ch, input logic v);
      rx[ch] = v;
      clks(BIT);
   endtask

   task automatic send(input int ch, input logic [7:0] b, input bit has_p,
                       input logic p, input logic stopv);
      bitt(ch, 1'b0);
      for (int i = 0; i < 8; i++) bitt(ch, b[i]);
      if (has_p) bitt(ch, p);
      bitt(ch, stopv);
   endtask

   task automatic pop(input int ch);
      rd[ch] = 1'b1;
      clks(1);
      rd[ch] = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         rx[i] = 1'b1;
         rd[i] = 1'b0;
      end
      #1;
      rst = 1'b1;
      clks(3);
      chk("rst_empty", emp[0], 1);
      chk("rst_full", ful[0], 0);
      chk("rst_busy", bsy[0], 0);
      chk("rst_data", dat[0], 0);
      chk("rst_perr", perr[0], 0);
      chk("rst_ferr", ferr[0], 0);
      chk("rst_ovr", ovr[0], 0);
      rst = 1'b0;
      clks(5);

      send(0, 8'hA5, 1'b0, 1'b0, 1'b1);
      clks(20);
      chk("a5_empty", emp[0], 0);
      chk("a5_data", dat[0], 8'hA5);
      chk("a5_perr", perr[0], 0);
      pop(0);
      chk("a5_pop_empty", emp[0], 1);

      send(1, 8'h03, 1'b1, 1'b0, 1'b1);
      clks(20);
      chk("even_ok_data", dat[1], 8'h03);
      chk("even_ok_perr", perr[1], 0);
      pop(1);
      send(1, 8'h03, 1'b1, 1'b1, 1'b1);
      clks(20);
      chk("even_bad_data", dat[1], 8'h03);
      chk("even_bad_perr", perr[1], 1);
      pop(1);
      chk("even_empty", emp[1], 1);
      send(2, 8'h03, 1'b1, 1'b0, 1'b1);
      clks(20);
      chk("odd_p0_data", dat[2], 8'h03);
      chk("odd_p0_perr", perr[2], 1);
      pop(2);
      send(2, 8'h03, 1'b1, 1'b1, 1'b1);
      clks(20);
      chk("odd_p1_perr", perr[2], 0);
      pop(2);

      fe = ferr_cnt[0];
      send(0, 8'h55, 1'b0, 1'b0, 1'b0);
      clks(3 * BIT);
      chk("brk_busy", bsy[0], 1);
      chk("brk_ferr_pulses", ferr_cnt[0] - fe, 1);
      chk("brk_empty", emp[0], 1);
      rx[0] = 1'b1;
      clks(10);
      chk("brk_release_busy", bsy[0], 0);
      send(0, 8'h12, 1'b0, 1'b0, 1'b1);
      clks(20);
      chk("after_brk_data", dat[0], 8'h12);
      pop(0);

      fe = ferr_cnt[0];
      rx[0] = 1'b0;
      clks(20);
      chk("glitch_busy_hi", bsy[0], 1);
      clks(20);
      rx[0] = 1'b1;
      clks(300);
      chk("glitch_busy_lo", bsy[0], 0);
      chk("glitch_empty", emp[0], 1);
      chk("glitch_ferr", ferr_cnt[0] - fe, 0);

      o = ovr_cnt[0];
      for (int k = 1; k <= 5; k++) send(0, 8'(k), 1'b0, 1'b0, 1'b1);
      clks(20);
      chk("ovr_full", ful[0], 1);
      chk("ovr_pulses", ovr_cnt[0] - o, 1);
      for (int k = 1; k <= 4; k++) begin
         chk("ovr_drain", dat[0], k);
         pop(0);
      end
      chk("ovr_drained_empty", emp[0], 1);

      o = ovr_cnt[0];
      for (int k = 1; k <= 4; k++) send(0, 8'(k), 1'b0, 1'b0, 1'b1);
      found = 1'b0;
      fork
         send(0, 8'h05, 1'b0, 1'b0, 1'b1);
         begin
            for (int c = 0; c < 2000 && !found; c++) begin
               @(negedge clk);
               if (u0.push) found = 1'b1;
            end
            if (found) begin
               rd[0] = 1'b1;
               @(posedge clk);
               #1;
               rd[0] = 1'b0;
            end
         end
      join
      clks(20);
      chk("pp_push_seen", found, 1);
      chk("pp_no_ovr", ovr_cnt[0] - o, 0);
      chk("pp_full", ful[0], 1);
      for (int k = 2; k <= 5; k++) begin
         chk("pp_drain", dat[0], k);
         pop(0);
      end
      chk("pp_empty", emp[0], 1);

      send(0, 8'h33, 1'b0, 1'b0, 1'b1);
      clks(20);
      chk("pre_rst_empty", emp[0], 0);
      bitt(0, 1'b0);
      for (int i = 0; i < 4; i++) bitt(0, 1'b0);
      rx[0] = 1'b1;
      clks(80);
      chk("mid_busy", bsy[0], 1);
      rst = 1'b1;
      clks(1);
      rst = 1'b0;
      chk("mid_rst_busy", bsy[0], 0);
      chk("mid_rst_empty", emp[0], 1);
      chk("mid_rst_full", ful[0], 0);
      chk("mid_rst_data", dat[0], 0);
      chk("mid_rst_perr", perr[0], 0);
      clks(80 + 4 * BIT + 200);
      chk("mid_rst_nobyte", emp[0], 1);
      chk("mid_rst_idle", bsy[0], 0);
      send(0, 8'h7E, 1'b0, 1'b0, 1'b1);
      clks(20);
      chk("7e_empty", emp[0], 0);
      chk("7e_data", dat[0], 8'h7E);
      chk("7e_perr", perr[0], 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
